md_sequencer: RTL

MD_SEQUENCER -- requirements
Module: md_sequencer

---
 rtl/md_sequencer_pkg.sv | 36 +++
 rtl/md_shift_core.sv | 47 ++++
 rtl/md_sequencer.sv | 118 +++++++++++
 3 files changed

// File: rtl/md_sequencer_pkg.sv
// md_sequencer_pkg: shared op codes, FSM encodings and operand helpers for the M-extension sequencer.
// Contents: func3_e (MUL..REMU), state_e (IDLE/CALC/DONE), LAST_ITER, op1_signed/op2_signed, mag.
package md_sequencer_pkg;

    typedef enum logic [2:0] {
        F_MUL    = 3'd0,
        F_MULH   = 3'd1,
        F_MULHSU = 3'd2,
        F_MULHU  = 3'd3,
        F_DIV    = 3'd4,
        F_DIVU   = 3'd5,
        F_REM    = 3'd6,
        F_REMU   = 3'd7
    } func3_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam logic [4:0] LAST_ITER = 5'd31;

    function automatic logic op1_signed(input func3_e f);
        return f == F_MULH || f == F_MULHSU || f == F_DIV || f == F_REM;
    endfunction

    function automatic logic op2_signed(input func3_e f);
        return f == F_MULH || f == F_DIV || f == F_REM;
    endfunction

    function automatic logic [31:0] mag(input logic [31:0] x, input logic sgn);
        return (sgn && x[31]) ? -x : x;
    endfunction

endpackage

// File: rtl/md_shift_core.sv
// md_shift_core: 32-step iterative shift-add multiplier / restoring divider on unsigned magnitudes.
// Ports: clk, rstn (async active-low); load latches a/b/is_div and clears the accumulator;
//        step performs one iteration; hi/lo hold product {hi,lo} or remainder hi / quotient lo.
module md_shift_core (
    input  logic        clk,
    input  logic        rstn,
    input  logic        load,
    input  logic        step,
    input  logic        is_div,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    logic [31:0] b_q;
    logic        div_q;
    logic [32:0] trial;
    logic [32:0] sum;

    // Remainder stays below the divisor, so a borrow shows up in bit 32 of the trial.
    always_comb begin
        trial = {hi, lo[31]} - {1'b0, b_q};
        sum   = {1'b0, hi} + (lo[0] ? {1'b0, b_q} : 33'd0);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hi    <= '0;
            lo    <= '0;
            b_q   <= '0;
            div_q <= 1'b0;
        end else if (load) begin
            hi    <= '0;
            lo    <= a;
            b_q   <= b;
            div_q <= is_div;
        end else if (step) begin
            if (div_q) begin
                hi <= trial[32] ? {hi[30:0], lo[31]} : trial[31:0];
                lo <= {lo[30:0], ~trial[32]};
            end else begin
                hi <= sum[32:1];
                lo <= {sum[0], lo[31:1]};
            end
        end
    end
endmodule

// File: rtl/md_sequencer.sv
// md_sequencer: RISC-V M-extension multiply/divide sequencer (IDLE -> CALC x32 -> DONE).
// Ports: clk, rstn (async active-low); md_req/md_func3/md_op1/md_op2/md_rd issue an op;
//        md_flush kills it; md_busy stalls decode; md_done pulses with md_result/md_wr_regindex.
// Build option: MD_FAST_MUL_EN gives all multiplies a single-cycle 33x33 path (accept -> DONE).
module md_sequencer
    import md_sequencer_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        md_req,
    input  logic [2:0]  md_func3,
    input  logic [31:0] md_op1,
    input  logic [31:0] md_op2,
    input  logic [4:0]  md_rd,
    input  logic        md_flush,
    output logic        md_busy,
    output logic        md_done,
    output logic [31:0] md_result,
    output logic [4:0]  md_wr_regindex
);
    state_e      state, state_nx;
    logic [4:0]  cnt;
    func3_e      f3_q;
    logic [4:0]  rd_q;
    logic        s1_q, s2_q, skip_q;
    logic [31:0] sp_res_q;
    func3_e      f3_in;
    logic        s1_in, s2_in, is_div, div_zero, div_ovf, accept, skip_in;
    logic [31:0] a_mag, b_mag, sp_div, sp_res_in, hi, lo, quo, rem, calc_res;
    logic [63:0] prod;

    always_comb begin
        f3_in    = func3_e'(md_func3);
        s1_in    = op1_signed(f3_in) & md_op1[31];
        s2_in    = op2_signed(f3_in) & md_op2[31];
        a_mag    = mag(md_op1, op1_signed(f3_in));
        b_mag    = mag(md_op2, op2_signed(f3_in));
        is_div   = md_func3[2];
        div_zero = md_op2 == 32'd0;
        div_ovf  = (f3_in == F_DIV || f3_in == F_REM) && md_op1 == 32'h8000_0000 && &md_op2;
        accept   = state == S_IDLE && md_req && !md_flush;
        sp_div   = div_zero ? (md_func3[1] ? md_op1 : 32'hFFFF_FFFF)
                            : (md_func3[1] ? 32'd0 : 32'h8000_0000);
    end

`ifdef MD_FAST_MUL_EN
    logic signed [65:0] fast_p;
    always_comb begin
        fast_p    = $signed({s1_in, md_op1}) * $signed({s2_in, md_op2});
        skip_in   = is_div ? (div_zero || div_ovf) : 1'b1;
        sp_res_in = is_div ? sp_div : (f3_in == F_MUL ? fast_p[31:0] : fast_p[63:32]);
    end
`else
    always_comb begin
        skip_in   = is_div && (div_zero || div_ovf);
        sp_res_in = sp_div;
    end
`endif

    md_shift_core u_core (
        .clk    (clk),
        .rstn   (rstn),
        .load   (accept),
        .step   (state == S_CALC),
        .is_div (is_div),
        .a      (a_mag),
        .b      (b_mag),
        .hi     (hi),
        .lo     (lo)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = md_flush           ? S_IDLE :
                   state == S_IDLE    ? (md_req ? (skip_in ? S_DONE : S_CALC) : S_IDLE) :
                   state == S_CALC    ? (cnt == LAST_ITER ? S_DONE : S_CALC) : S_IDLE;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt      <= '0;
            f3_q     <= F_MUL;
            rd_q     <= '0;
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            skip_q   <= 1'b0;
            sp_res_q <= '0;
        end else begin
            cnt <= (state == S_CALC && !md_flush) ? cnt + 5'd1 : 5'd0;
            if (accept) begin
                f3_q     <= f3_in;
                rd_q     <= md_rd;
                s1_q     <= s1_in;
                s2_q     <= s2_in;
                skip_q   <= skip_in;
                sp_res_q <= sp_res_in;
            end
        end
    end

    // Sign fixup: product/quotient negative iff operand signs differ, remainder follows dividend.
    always_comb begin
        prod     = (s1_q ^ s2_q) ? -{hi, lo} : {hi, lo};
        quo      = (s1_q ^ s2_q) ? -lo : lo;
        rem      = s1_q ? -hi : hi;
        calc_res = f3_q == F_MUL ? prod[31:0] : !f3_q[2] ? prod[63:32] : !f3_q[1] ? quo : rem;
        md_done        = state == S_DONE && !md_flush;
        md_result      = md_done ? (skip_q ? sp_res_q : calc_res) : 32'd0;
        md_wr_regindex = md_done ? rd_q : 5'd0;
        md_busy        = rstn && (state == S_CALC || accept);
    end
endmodule
